// File: rtl/uart_word_loader_if.sv
// uart_word_loader_if: byte-stream input, memory write port and status
// outputs of the UART word loader, bundled as one interface.
//   in_valid/in_data/in_ready  : byte stream from the UART receive FIFO
//   wr_valid/wr_ready          : write request handshake to program RAM
//   wr_addr/wr_data            : word address and little-endian word
//   busy/done/err/xorc         : frame status
// Modports: master = the loader (drives the write port and status),
//           slave  = the surrounding system (byte source, memory, observer).
interface uart_word_loader_if #(
  parameter int ADDR_W         = 23,
  parameter int BYTES_PER_WORD = 4
);
  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          in_ready;
  logic                          wr_valid;
  logic                          wr_ready;
  logic [ADDR_W-1:0]             wr_addr;
  logic [8*BYTES_PER_WORD-1:0]   wr_data;
  logic                          busy;
  logic                          done;
  logic                          err;
  logic [7:0]                    xorc;

  modport master (
    input  in_valid, in_data, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data, busy, done, err, xorc
  );

  modport slave (
    output in_valid, in_data, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data, busy, done, err, xorc
  );
endinterface

// File: rtl/uart_word_loader.sv
// uart_word_loader: parses a framed load command from a UART byte stream
//   SYNC | addr[4 LE] | count[4 LE] | count*BYTES_PER_WORD payload | [chk]
// and writes little-endian words of BYTES_PER_WORD bytes to consecutive
// word addresses with ready/valid backpressure.
// Ports:
//   clk_50mhz : clock, posedge
//   rst       : asynchronous active-high reset
//   bus       : uart_word_loader_if.master (byte in, write port, status)
// Build option: define UART_LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte; otherwise done pulses right after the last write and
// err is tied low.
module uart_word_loader #(
  parameter int         ADDR_W         = 23,
  parameter int         BYTES_PER_WORD = 4,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input logic              clk_50mhz,
  input logic              rst,
  uart_word_loader_if.master bus
);
  localparam int DW = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, WRITE, CHECK} state_t;

  state_t            state, state_nx;
  logic [2:0]        cnt;      // byte index within the current field/word
  logic [23:0]       sh;       // low three bytes of a 32-bit header field
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       len_q;    // words still to be written
  logic [DW-1:0]     word_q;
  logic [7:0]        xorc_q;
  logic              done_q;
  logic              done_set;
  logic              accept;
  logic              last_fld;
  logic              last_byte;
  logic [31:0]       fld;      // complete header field once its 4th byte arrives
`ifdef UART_LOADER_CHECKSUM_EN
  logic              err_q;
  logic              err_set;
`endif

  assign fld       = {bus.in_data, sh};
  assign last_fld  = (cnt == 3'd3);
  assign last_byte = (cnt == 3'(BYTES_PER_WORD - 1));
  // Byte acceptance is blocked while a word is pending, so a write
  // transfer and a byte acceptance never share a cycle.
  assign bus.in_ready = !rst && (state != WRITE);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done_set = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
    err_set  = 1'b0;
`endif
    case (state)
      IDLE:  if (accept && bus.in_data == SYNC_BYTE) state_nx = ADDR;
      ADDR:  if (accept && last_fld) state_nx = LEN;
      LEN:   if (accept && last_fld) begin
               if (fld == 32'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
                 state_nx = CHECK;
`else
                 state_nx = IDLE;
                 done_set = 1'b1;
`endif
               end else begin
                 state_nx = DATA;
               end
             end
      DATA:  if (accept && last_byte) state_nx = WRITE;
      WRITE: if (bus.wr_ready) begin
               if (len_q == 32'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
                 state_nx = CHECK;
`else
                 state_nx = IDLE;
                 done_set = 1'b1;
`endif
               end else begin
                 state_nx = DATA;
               end
             end
`ifdef UART_LOADER_CHECKSUM_EN
      CHECK: if (accept) begin
               state_nx = IDLE;
               if (bus.in_data == xorc_q) done_set = 1'b1;
               else                       err_set  = 1'b1;
             end
`endif
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      sh     <= '0;
      addr_q <= '0;
      len_q  <= '0;
      word_q <= '0;
      xorc_q <= '0;
      done_q <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      err_q  <= 1'b0;
`endif
    end else begin
      done_q <= done_set;
`ifdef UART_LOADER_CHECKSUM_EN
      if (err_set) err_q <= 1'b1;
`endif
      case (state)
        IDLE: if (accept && bus.in_data == SYNC_BYTE) begin
                cnt    <= '0;
                xorc_q <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                err_q  <= 1'b0;
`endif
              end
        ADDR, LEN: if (accept) begin
                xorc_q <= xorc_q ^ bus.in_data;
                if (last_fld) begin
                  cnt <= '0;
                  // Excess address bits above ADDR_W are dropped here.
                  if (state == ADDR) addr_q <= ADDR_W'(fld);
                  else               len_q  <= fld;
                end else begin
                  for (int b = 0; b < 3; b++)
                    if (cnt == 3'(b)) sh[b*8 +: 8] <= bus.in_data;
                  cnt <= cnt + 3'd1;
                end
              end
        DATA: if (accept) begin
                xorc_q <= xorc_q ^ bus.in_data;
                for (int b = 0; b < BYTES_PER_WORD; b++)
                  if (cnt == 3'(b)) word_q[b*8 +: 8] <= bus.in_data;
                cnt <= last_byte ? 3'd0 : cnt + 3'd1;
              end
        WRITE: if (bus.wr_ready) begin
                addr_q <= addr_q + ADDR_W'(1);
                len_q  <= len_q - 32'd1;
              end
        default: ;
      endcase
    end
  end

  assign bus.wr_valid = (state == WRITE);
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = word_q;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.xorc     = xorc_q;
`ifdef UART_LOADER_CHECKSUM_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif
endmodule
